adder_rr_arbiter: RTL and testbench

- Shares one 2-stage registered 16-bit adder pipeline among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter picks at most one request per cycle and tags it with the requester ID.
- The sum and carry-out come back on a single broadcast response port two cycles later, at a throughput of one operation per cycle.

---
 rtl/adder_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_adder_rr_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: NUM_REQ requesters share one 2-stage registered adder.
// A round-robin arbiter grants at most one request per cycle. The result comes
// back on a broadcast response port tagged with the requester ID, two edges
// after acceptance. The pipeline never stalls.
module adder_rr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       cfg_mask,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     busy
);

    // Index reached by stepping 'off' positions past 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Arbiter state
    logic [ID_W-1:0]    last_grant_q, last_grant_d;

    // Stage 1: captured operands
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   a1_q, a1_d;
    logic [WIDTH-1:0]   b1_q, b1_d;
    logic [ID_W-1:0]    id1_q, id1_d;

    // Stage 2: sum, carry and owner
    logic               v2_q, v2_d;
    logic [WIDTH-1:0]   sum2_q, sum2_d;
    logic               carry2_q, carry2_d;
    logic [ID_W-1:0]    id2_q, id2_d;

    // Grant datapath
    logic [NUM_REQ-1:0] eligible;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               accept;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [WIDTH:0]     add_res;

    assign eligible = req_valid & cfg_mask;

    // Round-robin scan: first eligible index after the last grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_any && eligible[wrap_idx(last_grant_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(last_grant_q, k);
            end
        end
    end

    // One-hot grant. Reset holds off every handshake.
    always_comb begin
        gnt_oh = '0;
        if (gnt_any) gnt_oh = NUM_REQ'(1) << gnt_idx;
        req_ready = reset ? '0 : gnt_oh;
    end

    // A grant is always a completed handshake: it only lands on a valid requester.
    assign accept = gnt_any & ~reset;
    assign a_sel  = req_a[gnt_idx*WIDTH +: WIDTH];
    assign b_sel  = req_b[gnt_idx*WIDTH +: WIDTH];

    // Add in WIDTH+1 bits so the top bit is the carry-out (carry-in is 0).
    assign add_res = {1'b0, a1_q} + {1'b0, b1_q};

    // Next state for the pointer and both stages.
    // Payload registers only load with valid data, so the response fields
    // hold their last value while rsp_valid is low.
    always_comb begin
        last_grant_d = accept ? gnt_idx : last_grant_q;
        v1_d         = accept;
        a1_d         = accept ? a_sel   : a1_q;
        b1_d         = accept ? b_sel   : b1_q;
        id1_d        = accept ? gnt_idx : id1_q;
        v2_d         = v1_q;
        sum2_d       = v1_q ? add_res[WIDTH-1:0] : sum2_q;
        carry2_d     = v1_q ? add_res[WIDTH]     : carry2_q;
        id2_d        = v1_q ? id1_q              : id2_q;
    end

    // State registers. Synchronous reset drops in-flight work and restarts
    // the pointer so requester 0 has top priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            v1_q         <= 1'b0;
            a1_q         <= '0;
            b1_q         <= '0;
            id1_q        <= '0;
            v2_q         <= 1'b0;
            sum2_q       <= '0;
            carry2_q     <= 1'b0;
            id2_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            v1_q         <= v1_d;
            a1_q         <= a1_d;
            b1_q         <= b1_d;
            id1_q        <= id1_d;
            v2_q         <= v2_d;
            sum2_q       <= sum2_d;
            carry2_q     <= carry2_d;
            id2_q        <= id2_d;
        end
    end

    assign rsp_valid = v2_q;
    assign rsp_id    = id2_q;
    assign rsp_sum   = sum2_q;
    assign rsp_carry = carry2_q;
    assign busy      = v1_q | v2_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Testbench for adder_rr_arbiter: stimulus with a reference grant model
// feeding a queue of expected responses; a separate monitor checks the
// response port on every falling edge.
module tb_adder_rr_arbiter;
    localparam int W  = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     cfg_mask = '0;
    logic [NR-1:0]     req_valid = '0;
    logic [W*NR-1:0]   req_a = '0;
    logic [W*NR-1:0]   req_b = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              busy;

    adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clock(clock), .reset(reset), .cfg_mask(cfg_mask), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int       due;
        int       id;
        int       sum;
        int       carry;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         model_last = NR - 1;
    logic [W*NR-1:0] va, vb;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Round-robin rule: first eligible index after the previous grant.
    function automatic int pick(input int last, input logic [NR-1:0] elig);
        for (int k = 1; k <= NR; k++)
            if (elig[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    // One cycle: drive inputs, check grant and busy, queue expected result.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] m, input logic r);
        int g, exp_busy, s;
        logic [NR-1:0] exp_rdy;
        @(posedge clock);
        #1;
        req_valid = v; cfg_mask = m; req_a = va; req_b = vb; reset = r;
        #1;
        g = r ? -1 : pick(model_last, v & m);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        exp_busy = 0;
        foreach (q[i]) if (q[i].due <= cyc + 1) exp_busy = 1;
        chk("busy", int'(busy), exp_busy);
        if (r) begin
            // Results due after the reset edge are discarded.
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].due > cyc) q.delete(i);
            model_last = NR - 1;
        end else if (g >= 0) begin
            s = int'(va[g*W +: W]) + int'(vb[g*W +: W]);
            q.push_back('{due: cyc + 2, id: g, sum: s % 65536, carry: s / 65536});
            model_last = g;
        end
    endtask

    // Monitor: a response is due exactly when the queue head says so.
    int last_id = 0, last_sum = 0, last_carry = 0;
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", int'(rsp_valid), 1);
            chk("rsp_id", int'(rsp_id), e.id);
            chk("rsp_sum", int'(rsp_sum), e.sum);
            chk("rsp_carry", int'(rsp_carry), e.carry);
            last_id = e.id; last_sum = e.sum; last_carry = e.carry;
        end else begin
            chk("rsp_valid_idle", int'(rsp_valid), 0);
            chk("rsp_hold", int'({rsp_carry, rsp_id, rsp_sum}),
                (last_carry << (IW + W)) | (last_id << W) | last_sum);
        end
        if (reset) begin
            last_id = 0; last_sum = 0; last_carry = 0;
        end
    end

    initial begin
        va = '0; vb = '0;
        repeat (3) step('0, 4'hF, 1'b1);
        repeat (2) step('0, 4'hF, 1'b0);

        // Single request from requester 0
        va[0*W +: W] = 16'h1234; vb[0*W +: W] = 16'h0001;
        step(4'b0001, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b0);

        // Overflow on requester 2
        va[2*W +: W] = 16'hFFFF; vb[2*W +: W] = 16'h0001;
        step(4'b0100, 4'hF, 1'b0);
        repeat (3) step(4'b0000, 4'hF, 1'b0);

        // All eligible for 8 cycles: a_i = i, b_i = 0x0100
        for (int i = 0; i < NR; i++) begin
            va[i*W +: W] = W'(i); vb[i*W +: W] = 16'h0100;
        end
        repeat (8) step(4'b1111, 4'hF, 1'b0);
        repeat (3) step(4'b0000, 4'hF, 1'b0);

        // Masked: only 1 and 3, then only 0
        repeat (4) step(4'b1111, 4'b1010, 1'b0);
        repeat (3) step(4'b1111, 4'b0001, 1'b0);
        repeat (3) step(4'b0000, 4'hF, 1'b0);

        // Reset mid-operation, then restart with 0110
        step(4'b0001, 4'hF, 1'b0);
        step(4'b0001, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b1);
        step(4'b0110, 4'hF, 1'b0);
        repeat (3) step(4'b0000, 4'hF, 1'b0);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            logic [NR-1:0] rv, rm;
            for (int i = 0; i < NR; i++) begin
                va[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
                vb[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h0001 : W'($urandom);
            end
            rv = NR'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? NR'($urandom) : 4'hF;
            step(rv, rm, $urandom_range(0, 99) == 0);
        end
        repeat (4) step(4'b0000, 4'hF, 1'b0);
        chk("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
